dma_job_scheduler: RTL
======================

# dma_job_scheduler

Sequencer and arbiter that sits in front of the `dma_design` register file and shares that single DMA channel among `NUM_REQ` requesters. It grants one requester at a time with round-robin arbitration and programs the job over the register bus: IO_ADDR, then MEM_ADDR, then CTRL with the start bit. It then polls STATUS until the transfer completes or times out, reads back TRANSFER_COUNT, and returns a one-cycle completion to the granted requester.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `POLL_LIMIT`, default 1024: maximum STATUS reads per job before timeout.
- `POLL_GAP`, default 4: idle cycles between consecutive STATUS reads, ≥0.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_REQ  per-requester job request, level.
- `req_io_addr`  in  NUM_REQ*32  IO address; requester i uses slice [32i+31:32i].
- `req_mem_addr`  in  NUM_REQ*32  memory address, same slicing.
- `req_w_count`  in  NUM_REQ*15  word count; requester i uses slice [15i+14:15i].
- `req_io_mem`  in  NUM_REQ  direction bit.
- `gnt`  out  NUM_REQ  one-hot, one-cycle accept pulse.
- `done`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `resp_count`  out  32  TRANSFER_COUNT readback; valid with `done`, held until the next `done`.
- `resp_err`  out  1  job error flag; valid with `done`, held until the next `done`.
- `sched_busy`  out  1  high whenever the FSM is not in IDLE.
- `reg_wr_en`, `reg_rd_en`  out  1  register-bus strobes.
- `reg_addr`, `reg_wdata`  out  32  register-bus address and write data.
- `reg_rdata`  in  32  register-bus read data. It is registered in the target: data for `reg_rd_en` asserted in cycle N is sampled in cycle N+1.

## Operation
- FSM states: IDLE, WR_IO, WR_MEM, WR_CTRL, SETTLE, POLL_RD, POLL_CHK, GAP, CNT_RD, CNT_CHK, RESP.
- Round-robin arbitration:
  - In IDLE with any `req` high, the winner is the first asserted index at or after `rr_ptr`, wrapping.
  - On grant, `rr_ptr` ← winner+1 mod NUM_REQ.
  - Index, io_addr, mem_addr, w_count and io_mem are captured on the edge leaving IDLE.
- Bus writes, one cycle each:
  - WR_IO: addr 0x408, wdata io_addr.
  - WR_MEM: addr 0x40C, wdata mem_addr.
  - WR_CTRL: addr 0x404, wdata {15'h0, io_mem, w_count, 1'b1}.
- SETTLE: one idle cycle so the datapath's busy bit is visible before the first poll.
- POLL_RD drives `reg_rd_en` with addr 0x414. POLL_CHK samples `reg_rdata` and increments `poll_cnt`:
  - bit1 (done)=1 and bit0 (busy)=0: record err = bit2, go to CNT_RD.
  - Else, if `poll_cnt` == POLL_LIMIT: err=1, go to CNT_RD.
  - Else go to GAP, wait POLL_GAP cycles (skip GAP if 0), then POLL_RD.
- CNT_RD reads 0x418. CNT_CHK latches `resp_count` from `reg_rdata`.
- RESP: pulse `done[idx]`, drive `resp_err`, return to IDLE.
- All bus outputs are decoded from registered state and captured fields only, with no combinational path from inputs. Outside bus states, strobes, addr and wdata are 0. `reg_wr_en` and `reg_rd_en` are never high together.
- Requester contract:
  - Hold `req` and its fields stable until `gnt`.
  - Deassert `req` in the cycle after `gnt`, or the job is re-requested.
  - Fields may change after `gnt`.

## Timing
- Reset, asynchronous: state IDLE, `rr_ptr`=0, `poll_cnt`=0. `gnt`, `done`, `resp_count`, `resp_err`, `sched_busy`, `reg_wr_en`, `reg_rd_en`, `reg_addr`, `reg_wdata` are all 0.
- Reset mid-job abandons the job with no `done` pulse. The datapath shares `rst_n`.
- `req` seen in IDLE at cycle 0:
  - `gnt` and WR_IO in cycle 1, WR_MEM in cycle 2, WR_CTRL in cycle 3, SETTLE in cycle 4.
  - First POLL_RD in cycle 5; first POLL_CHK in cycle 6.
- Completion: CNT_RD 1 cycle, CNT_CHK 1 cycle, `done` in the following cycle, IDLE in the cycle after.
- Back-to-back jobs: next `gnt` at earliest 2 cycles after `done`, since one IDLE cycle is required.
- w_count=0 is legal. The datapath returns TRANSFER_COUNT = w_count+1 for a normal completion.
- Timeout: exactly POLL_LIMIT STATUS reads, then the count is still read and `resp_err`=1.
- A `req` arriving mid-job waits; there is no preemption.

## Test plan
- Single job, req[1], io 0x1000, mem 0x2000, w_count 5, io_mem 1:
  - Bus writes 0x408←0x1000, 0x40C←0x2000, 0x404←0x0001000B.
  - `done[1]`, `resp_count`=6, `resp_err`=0.
  - Write cycles land exactly in cycles 1–3.
- All four requesters continuously requesting, three rounds: grant order 0,1,2,3,0,1,2,3,… with every `gnt` and `done` one-hot.
- w_count=0 job → `resp_count`=1, `resp_err`=0. Polls spaced POLL_GAP+2 cycles apart.
- Bench model holds STATUS busy=1, with POLL_LIMIT=8 → exactly 8 STATUS reads, then `done` with `resp_err`=1.
- Model returns STATUS=0x6, i.e. done with error bit → `resp_err`=1, `resp_count` = value returned at 0x418.
- `rst_n` low during POLL_GAP → all outputs 0 immediately with no `done`. A new req[2] after reset is granted first with `rr_ptr`=0.

Source files
------------

// File: rtl/dma_job_scheduler.sv
// ----------------------------------------------------------------------------
// dma_job_scheduler
//
// Shares one dma_design channel among NUM_REQ requesters. A round-robin
// arbiter picks a requester while the FSM is idle. The job is then programmed
// over the register bus in this order: IO_ADDR, MEM_ADDR, then CTRL with the
// start bit. STATUS is polled until the transfer is done or POLL_LIMIT reads
// have been spent. TRANSFER_COUNT is read back, and the granted requester
// gets a one-cycle completion pulse.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req                per-requester level request
//   req_io_addr        NUM_REQ x 32-bit IO address   (slice [32i+31:32i])
//   req_mem_addr       NUM_REQ x 32-bit memory address
//   req_w_count        NUM_REQ x 15-bit word count   (slice [15i+14:15i])
//   req_io_mem         NUM_REQ direction bits
//   gnt                one-hot accept pulse (first programming cycle)
//   done               one-hot completion pulse
//   resp_count         TRANSFER_COUNT readback, held until the next done
//   resp_err           job error flag, held until the next done
//   sched_busy         FSM not idle
//   reg_wr_en/rd_en    register-bus strobes
//   reg_addr/wdata     register-bus address and write data
//   reg_rdata          register-bus read data (one cycle after reg_rd_en)
// ----------------------------------------------------------------------------
module dma_job_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int POLL_LIMIT = 1024,
    parameter int POLL_GAP   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] req_io_addr,
    input  logic [NUM_REQ*32-1:0] req_mem_addr,
    input  logic [NUM_REQ*15-1:0] req_w_count,
    input  logic [NUM_REQ-1:0]    req_io_mem,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic [31:0]           resp_count,
    output logic                  resp_err,
    output logic                  sched_busy,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    output logic [31:0]           reg_addr,
    output logic [31:0]           reg_wdata,
    input  logic [31:0]           reg_rdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int GW = $clog2(POLL_GAP + 2);

    // Value of poll_cnt_q while checking the final permitted STATUS read
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0404;
    localparam logic [31:0] ADDR_IO     = 32'h0000_0408;
    localparam logic [31:0] ADDR_MEM    = 32'h0000_040C;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0414;
    localparam logic [31:0] ADDR_COUNT  = 32'h0000_0418;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_IO    = 4'd1;
    localparam logic [3:0] S_WR_MEM   = 4'd2;
    localparam logic [3:0] S_WR_CTRL  = 4'd3;
    localparam logic [3:0] S_SETTLE   = 4'd4;
    localparam logic [3:0] S_POLL_RD  = 4'd5;
    localparam logic [3:0] S_POLL_CHK = 4'd6;
    localparam logic [3:0] S_GAP      = 4'd7;
    localparam logic [3:0] S_CNT_RD   = 4'd8;
    localparam logic [3:0] S_CNT_CHK  = 4'd9;
    localparam logic [3:0] S_RESP     = 4'd10;

    logic [3:0]    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic [31:0]   resp_count_q, resp_count_d;
    logic          resp_err_q, resp_err_d;

    // Job fields captured at grant; only ever observed in bus states
    logic [31:0]   io_addr_q;
    logic [31:0]   mem_addr_q;
    logic [14:0]   w_count_q;
    logic          io_mem_q;

    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] rr_next;
    logic [NUM_REQ-1:0] idx_oh;

    // Round-robin pick: first asserted request at or after rr_ptr, wrapping
    always_comb begin
        int            cand;
        logic [IW-1:0] cidx;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        cidx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            cidx = IW'(cand);
            if (!win_vld && req[cidx]) begin
                win_vld = 1'b1;
                win_idx = cidx;
            end
        end
        rr_next = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        poll_cnt_d   = poll_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        idx_d        = idx_q;
        err_d        = err_q;
        resp_count_d = resp_count_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d    = S_WR_IO;
                    idx_d      = win_idx;
                    rr_ptr_d   = rr_next;
                    poll_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end
            S_WR_IO:   state_d = S_WR_MEM;
            S_WR_MEM:  state_d = S_WR_CTRL;
            S_WR_CTRL: state_d = S_SETTLE;
            S_SETTLE:  state_d = S_POLL_RD;
            S_POLL_RD: state_d = S_POLL_CHK;
            S_POLL_CHK: begin
                poll_cnt_d = poll_cnt_q + PW'(1);
                // done=1 with busy=0 finishes; bit2 carries the datapath error
                if (reg_rdata[1] && !reg_rdata[0]) begin
                    err_d   = reg_rdata[2];
                    state_d = S_CNT_RD;
                end else if (poll_cnt_q == POLL_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_CNT_RD;
                end else if (POLL_GAP == 0) begin
                    state_d = S_POLL_RD;
                end else begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_POLL_RD;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_CNT_RD: state_d = S_CNT_CHK;
            S_CNT_CHK: begin
                resp_count_d = reg_rdata;
                resp_err_d   = err_q;
                state_d      = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            poll_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            resp_count_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            poll_cnt_q   <= poll_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            resp_count_q <= resp_count_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && win_vld) begin
            io_addr_q  <= req_io_addr[32*win_idx +: 32];
            mem_addr_q <= req_mem_addr[32*win_idx +: 32];
            w_count_q  <= req_w_count[15*win_idx +: 15];
            io_mem_q   <= req_io_mem[win_idx];
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_oh
        assign idx_oh[g] = (idx_q == IW'(g));
    end

    // Everything below decodes registered state only, so no input reaches an output
    always_comb begin
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        case (state_q)
            S_WR_IO: begin
                reg_wr_en = 1'b1;
                reg_addr  = ADDR_IO;
                reg_wdata = io_addr_q;
            end
            S_WR_MEM: begin
                reg_wr_en = 1'b1;
                reg_addr  = ADDR_MEM;
                reg_wdata = mem_addr_q;
            end
            S_WR_CTRL: begin
                reg_wr_en = 1'b1;
                reg_addr  = ADDR_CTRL;
                reg_wdata = {15'h0, io_mem_q, w_count_q, 1'b1};
            end
            S_POLL_RD: begin
                reg_rd_en = 1'b1;
                reg_addr  = ADDR_STATUS;
            end
            S_CNT_RD: begin
                reg_rd_en = 1'b1;
                reg_addr  = ADDR_COUNT;
            end
            default: ;
        endcase
    end

    assign gnt        = (state_q == S_WR_IO) ? idx_oh : '0;
    assign done       = (state_q == S_RESP)  ? idx_oh : '0;
    assign resp_count = resp_count_q;
    assign resp_err   = resp_err_q;
    assign sched_busy = (state_q != S_IDLE);

endmodule
